// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : text_pkg
//  Description : Shared types and default geometry for the character-cell
//                text controller (host command codes, controller states,
//                blank fill code, 640x480 / 16x16 cell geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package text_pkg;

    // Host command codes carried on wr_cmd
    typedef enum logic [1:0] {
        CMD_PUT = 2'b00,
        CMD_NL  = 2'b01,
        CMD_BS  = 2'b10,
        CMD_CLR = 2'b11
    } cmd_e;

    // Write-side controller states
    typedef enum logic [1:0] {
        ST_INIT_CLR = 2'b00,
        ST_IDLE     = 2'b01,
        ST_ROW_CLR  = 2'b10
    } state_e;

    localparam int         DEF_COLS      = 40;
    localparam int         DEF_ROWS      = 30;
    localparam int         DEF_CELL_LOG2 = 4;
    localparam logic [6:0] BLANK_CODE    = 7'h20;

endpackage
`default_nettype wire

// File: rtl/text_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_ctrl_if
//  Description : Host command bus of the text controller.
//                master : host side (drives wr_valid/wr_cmd/wr_char)
//                slave  : controller side (drives wr_ready, cursor, busy)
//  Ports       : wr_valid, wr_ready, wr_cmd, wr_char, cursor_col,
//                cursor_row, busy
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_buffer_ctrl_if
    import text_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) ();
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic          wr_valid;
    logic          wr_ready;
    cmd_e          wr_cmd;
    logic [6:0]    wr_char;
    logic [CW-1:0] cursor_col;
    logic [RW-1:0] cursor_row;
    logic          busy;

    modport master (
        output wr_valid, wr_cmd, wr_char,
        input  wr_ready, cursor_col, cursor_row, busy
    );

    modport slave (
        input  wr_valid, wr_cmd, wr_char,
        output wr_ready, cursor_col, cursor_row, busy
    );
endinterface
`default_nettype wire

// File: rtl/char_ram.sv
`default_nettype none
// ============================================================================
//  Module      : char_ram
//  Description : Simple dual-port character RAM, one write and one
//                registered read per cycle. A same-address read/write
//                returns the old contents (read-first).
//  Ports       : clk, we/waddr/wdata (write), raddr/rdata (read, 1 cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module char_ram #(
    parameter int DEPTH = 1200,
    parameter int AW    = 11,
    parameter int DW    = 7
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Both accesses in one block with non-blocking writes: the read samples
    // the array before the write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule
`default_nettype wire

// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_ctrl
//  Description : Character-cell text controller. Maps pixel coordinates to
//                a cell and returns its code after a fixed 2-cycle latency;
//                executes host put/newline/backspace/clear commands, keeps
//                the cursor and sequences full-screen and row clear sweeps.
//  Ports       : pix_clk, rst_n (sync, active-low)
//                i_x/i_y/i_de -> o_x/o_y/o_de + character (2-cycle delay)
//                host         : text_buffer_ctrl_if.slave command bus
//  Revision    : 1.0 - initial release
// ============================================================================
module text_buffer_ctrl
    import text_pkg::*;
#(
    parameter int         COLS      = DEF_COLS,
    parameter int         ROWS      = DEF_ROWS,
    parameter int         CELL_LOG2 = DEF_CELL_LOG2,
    parameter logic [6:0] BLANK     = BLANK_CODE
) (
    input  wire logic        pix_clk,
    input  wire logic        rst_n,
    input  wire logic [11:0] i_x,
    input  wire logic [11:0] i_y,
    input  wire logic        i_de,
    output logic      [11:0] o_x,
    output logic      [11:0] o_y,
    output logic             o_de,
    output logic      [6:0]  character,
    text_buffer_ctrl_if.slave host
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = $clog2(ROWS * COLS);
    localparam int DEPTH = ROWS * COLS;

    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_SWP  = AW'(COLS - 1);

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                                input logic [CW-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    // ---------------- read pipeline ----------------
    logic [11:0]   x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic          de1_q, de1_d, de2_q, de2_d;
    logic          rng1_q, rng1_d, rng2_q, rng2_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [11:0]   pix_col, pix_row;
    logic [6:0]    ram_rdata;

    // ---------------- write side ----------------
    state_e        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          ready_q, ready_d;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [6:0]    ram_wdata;
    logic          advance;

    always_comb begin
        pix_col = i_x >> CELL_LOG2;
        pix_row = i_y >> CELL_LOG2;
        x1_d    = i_x;
        y1_d    = i_y;
        de1_d   = i_de;
        x2_d    = x1_q;
        y2_d    = y1_q;
        de2_d   = de1_q;
        rng1_d  = i_de && (pix_col < 12'(COLS)) && (pix_row < 12'(ROWS));
        rng2_d  = rng1_q;
        // Out-of-range addresses are don't-care: the flag masks the result.
        raddr_d = cell_addr(pix_row[RW-1:0], pix_col[CW-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        col_d     = col_q;
        row_d     = row_q;
        ready_d   = ready_q;
        ram_we    = 1'b0;
        ram_waddr = sweep_q;
        ram_wdata = BLANK;
        advance   = 1'b0;

        case (state_q)
            ST_INIT_CLR: begin
                ram_we    = 1'b1;
                ram_waddr = sweep_q;
                col_d     = '0;
                row_d     = '0;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                    ready_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                end
            end

            ST_ROW_CLR: begin
                // row_q already holds the freshly advanced row
                ram_we    = 1'b1;
                ram_waddr = cell_addr(row_q, sweep_q[CW-1:0]);
                if (sweep_q == LAST_SWP) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                    ready_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                end
            end

            ST_IDLE: begin
                if (host.wr_valid && ready_q) begin
                    case (host.wr_cmd)
                        CMD_PUT: begin
                            ram_we    = 1'b1;
                            ram_waddr = cell_addr(row_q, col_q);
                            ram_wdata = host.wr_char;
                            if (col_q != LAST_COL) begin
                                col_d = col_q + CW'(1);
                            end else begin
                                col_d   = '0;
                                advance = 1'b1;
                            end
                        end
                        CMD_NL: begin
                            col_d   = '0;
                            advance = 1'b1;
                        end
                        CMD_BS: begin
                            if (col_q != '0) begin
                                col_d     = col_q - CW'(1);
                                ram_we    = 1'b1;
                                ram_waddr = cell_addr(row_q, col_q - CW'(1));
                            end else if (row_q != '0) begin
                                row_d     = row_q - RW'(1);
                                col_d     = LAST_COL;
                                ram_we    = 1'b1;
                                ram_waddr = cell_addr(row_q - RW'(1), LAST_COL);
                            end
                        end
                        CMD_CLR: begin
                            col_d   = '0;
                            row_d   = '0;
                            sweep_d = '0;
                            state_d = ST_INIT_CLR;
                            ready_d = 1'b0;
                        end
                        default: ;
                    endcase
                    // Advancing from the last row wraps and clears row 0.
                    if (advance) begin
                        row_d   = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
                        sweep_d = '0;
                        state_d = ST_ROW_CLR;
                        ready_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_INIT_CLR;
                sweep_d = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            de1_q   <= 1'b0;
            de2_q   <= 1'b0;
            rng1_q  <= 1'b0;
            rng2_q  <= 1'b0;
            raddr_q <= '0;
            state_q <= ST_INIT_CLR;
            sweep_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            de1_q   <= de1_d;
            de2_q   <= de2_d;
            rng1_q  <= rng1_d;
            rng2_q  <= rng2_d;
            raddr_q <= raddr_d;
            state_q <= state_d;
            sweep_q <= sweep_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ready_q <= ready_d;
        end
    end

    char_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (7)
    ) u_ram (
        .clk   (pix_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (raddr_q),
        .rdata (ram_rdata)
    );

    assign o_x             = x2_q;
    assign o_y             = y2_q;
    assign o_de            = de2_q;
    assign character       = rng2_q ? ram_rdata : BLANK;
    assign host.wr_ready   = ready_q;
    assign host.busy       = !ready_q;
    assign host.cursor_col = col_q;
    assign host.cursor_row = row_q;
endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_buffer_ctrl
//  Description : Directed self-checking bench for text_buffer_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_buffer_ctrl;
    import text_pkg::*;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int LIMIT = 3000;

    logic        pix_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [11:0] i_x     = '0;
    logic [11:0] i_y     = '0;
    logic        i_de    = 1'b0;
    logic [11:0] o_x, o_y;
    logic        o_de;
    logic [6:0]  character;

    int errors = 0;
    int checks = 0;

    logic [6:0] exp_mem [ROWS][COLS];

    text_buffer_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    text_buffer_ctrl dut (
        .pix_clk   (pix_clk),
        .rst_n     (rst_n),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_de      (i_de),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_de      (o_de),
        .character (character),
        .host      (bus.slave)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic step();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=event within %0d cycles", tag, LIMIT);
    endtask

    task automatic fill_exp(input logic [6:0] v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_mem[r][c] = v;
    endtask

    // Drive one pixel in the middle of cell (r,c); returns character 2 cycles later.
    task automatic read_cell(input int r, input int c, output logic [6:0] ch);
        i_x  = 12'(c * 16 + 7);
        i_y  = 12'(r * 16 + 9);
        i_de = 1'b1;
        step();
        step();
        ch   = character;
        i_de = 1'b0;
    endtask

    task automatic scan(input string tag);
        logic [6:0] ch;
        int bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, ch);
                if (ch !== exp_mem[r][c]) bad++;
            end
        check(tag, bad, 0);
    endtask

    // Count cycles until busy drops (wr_ready rises)
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < LIMIT) begin
            step();
            n++;
        end
    endtask

    task automatic send_cmd(input cmd_e c, input logic [6:0] ch);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_cmd   = c;
        bus.wr_char  = ch;
        while (!bus.wr_ready && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("cmd_accept");
        step();
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] ch;
        int         n;

        bus.wr_valid = 1'b0;
        bus.wr_cmd   = CMD_PUT;
        bus.wr_char  = 7'h00;
        i_x          = 12'd123;
        i_y          = 12'd77;
        i_de         = 1'b1;

        // ---- reset state ----
        repeat (3) step();
        check("rst_o_x", o_x, 0);
        check("rst_o_y", o_y, 0);
        check("rst_o_de", o_de, 0);
        check("rst_char", character, 7'h20);
        check("rst_busy", bus.busy, 1);
        check("rst_ready", bus.wr_ready, 0);
        check("rst_cursor", {bus.cursor_row, bus.cursor_col}, 0);

        // ---- initial clear lasts exactly 1200 cycles ----
        i_de  = 1'b0;
        rst_n = 1'b1;
        wait_idle(n);
        check("init_clr_cycles", n, 1200);
        check("init_ready", bus.wr_ready, 1);
        fill_exp(7'h20);
        scan("init_scan_blank");

        // ---- put '1' at (0,0), read it back through the pipeline ----
        send_cmd(CMD_PUT, 7'h31);
        exp_mem[0][0] = 7'h31;
        i_x  = 12'd5;
        i_y  = 12'd3;
        i_de = 1'b1;
        step();
        step();
        check("put_char", character, 7'h31);
        check("put_o_x", o_x, 5);
        check("put_o_y", o_y, 3);
        check("put_o_de", o_de, 1);
        check("put_cursor_col", bus.cursor_col, 1);
        check("put_cursor_row", bus.cursor_row, 0);
        i_de = 1'b0;

        // ---- backspace from (0,1) -> (0,0) and blanks it ----
        send_cmd(CMD_BS, 7'h00);
        exp_mem[0][0] = 7'h20;
        check("bs_cursor_col", bus.cursor_col, 0);
        read_cell(0, 0, ch);
        check("bs_cell_blank", ch, 7'h20);

        // ---- 40 back-to-back puts fill row 0 and wrap to row 1 ----
        bus.wr_valid = 1'b1;
        bus.wr_cmd   = CMD_PUT;
        bus.wr_char  = 7'h32;
        repeat (40) step();
        bus.wr_valid = 1'b0;
        check("wrap_busy", bus.busy, 1);
        wait_idle(n);
        check("row_clr_cycles", n, 40);
        check("wrap_cursor", {bus.cursor_row, bus.cursor_col}, {5'd1, 6'd0});
        for (int c = 0; c < COLS; c++) exp_mem[0][c] = 7'h32;
        scan("wrap_scan");

        // ---- out-of-range / inactive pixels read blank ----
        send_cmd(CMD_PUT, 7'h45);          // (1,0) = 'E', aliased by x=640,y=0
        exp_mem[1][0] = 7'h45;
        i_x  = 12'd640;
        i_y  = 12'd0;
        i_de = 1'b1;
        step();
        step();
        check("x640_blank", character, 7'h20);
        i_x  = 12'd0;
        i_de = 1'b0;
        step();
        step();
        check("de0_blank", character, 7'h20);

        // ---- walk to row 29, then newline wraps to row 0 and clears it ----
        repeat (28) send_cmd(CMD_NL, 7'h00);
        wait_idle(n);
        check("row29_cursor", {bus.cursor_row, bus.cursor_col}, {5'd29, 6'd0});
        send_cmd(CMD_PUT, 7'h41);
        exp_mem[29][0] = 7'h41;
        send_cmd(CMD_NL, 7'h00);
        check("nl_wrap_busy", bus.busy, 1);
        wait_idle(n);
        check("nl_wrap_cycles", n, 40);
        check("nl_wrap_cursor", {bus.cursor_row, bus.cursor_col}, 0);
        for (int c = 0; c < COLS; c++) exp_mem[0][c] = 7'h20;
        scan("nl_wrap_scan");

        // ---- backspace at (0,0) is a no-op ----
        send_cmd(CMD_BS, 7'h00);
        check("bs00_busy", bus.busy, 0);
        check("bs00_cursor", {bus.cursor_row, bus.cursor_col}, 0);

        // ---- backspace at (1,0) goes to (0,39) and blanks it ----
        bus.wr_valid = 1'b1;
        bus.wr_cmd   = CMD_PUT;
        bus.wr_char  = 7'h43;
        repeat (40) step();
        bus.wr_valid = 1'b0;
        wait_idle(n);
        for (int c = 0; c < COLS; c++) begin
            exp_mem[0][c] = 7'h43;
            exp_mem[1][c] = 7'h20;
        end
        send_cmd(CMD_BS, 7'h00);
        exp_mem[0][39] = 7'h20;
        check("bs_row_cursor", {bus.cursor_row, bus.cursor_col}, {5'd0, 6'd39});
        check("bs_row_busy", bus.busy, 0);
        scan("bs_row_scan");

        // ---- clear command, reset at sweep address 500 restarts sweep ----
        send_cmd(CMD_CLR, 7'h00);
        check("clr_busy", bus.busy, 1);
        check("clr_cursor", {bus.cursor_row, bus.cursor_col}, 0);
        repeat (500) step();
        rst_n = 1'b0;
        repeat (2) step();
        check("mid_rst_busy", bus.busy, 1);
        rst_n = 1'b1;
        wait_idle(n);
        check("restart_cycles", n, 1200);
        fill_exp(7'h20);
        scan("restart_scan_blank");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
